// File: rtl/downscale_avg2x.sv
// rtl/downscale_avg2x.sv - 2x2 box-filter downscaler from source ROM into framebuffer
// DOWNSCALE_ROUND_EN selects round-half-up averaging; truncation otherwise.
module downscale_avg2x #(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int ADDR_W = 19,
    parameter int PIX_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [PIX_W-1:0]  ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;
    state_t state, next_state;

    logic [XW-1:0]    x_cnt, t_x;
    logic [YW-1:0]    y_cnt, t_y;
    logic             t_valid;
    logic [PIX_W-1:0] hold_px;
    logic [ADDR_W-1:0] wr_cnt;
    logic [PIX_W:0]   line_buf [IMG_W/2];
    logic [XW-2:0]    lb_idx;
    logic [PIX_W:0]   pair_sum;
    logic [PIX_W+1:0] total;
    logic [PIX_W-1:0] avg;
    logic             accept;
    logic             wr_fire;

    assign accept = start && (state == S_IDLE || state == S_DONE);
    assign busy   = (state == S_READ) || (state == S_DRAIN);
    assign done   = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_READ;
            S_READ:  if (rom_addr == LAST_ADDR) next_state = S_DRAIN;
            S_DRAIN: if (ram_wren) next_state = S_DONE;
            S_DONE:  if (start) next_state = S_READ;
            default: next_state = S_IDLE;
        endcase
    end

    // x/y tags are delayed one cycle so they line up with the returning ROM word
    always_comb begin
        lb_idx   = t_x[XW-1:1];
        pair_sum = {1'b0, hold_px} + {1'b0, rom_data};
        total    = {1'b0, pair_sum} + {1'b0, line_buf[lb_idx]};
        wr_fire  = t_valid && t_x[0] && t_y[0];
`ifdef DOWNSCALE_ROUND_EN
        avg = PIX_W'((total + 2) >> 2);
`else
        avg = PIX_W'(total >> 2);
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rom_addr   <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            t_valid    <= 1'b0;
            t_x        <= '0;
            t_y        <= '0;
            hold_px    <= '0;
            wr_cnt     <= '0;
            ram_wraddr <= '0;
            ram_data   <= '0;
            ram_wren   <= 1'b0;
        end else begin
            if (accept) begin
                rom_addr <= '0;
                x_cnt    <= '0;
                y_cnt    <= '0;
                wr_cnt   <= '0;
            end else if (state == S_READ && rom_addr != LAST_ADDR) begin
                rom_addr <= rom_addr + ADDR_W'(1);
                if (x_cnt == XW'(IMG_W - 1)) begin
                    x_cnt <= '0;
                    y_cnt <= y_cnt + YW'(1);
                end else begin
                    x_cnt <= x_cnt + XW'(1);
                end
            end
            t_valid <= (state == S_READ);
            t_x     <= x_cnt;
            t_y     <= y_cnt;
            if (t_valid && !t_x[0])
                hold_px <= rom_data;
            ram_wren <= wr_fire;
            if (wr_fire) begin
                ram_data   <= avg;
                ram_wraddr <= wr_cnt;
                wr_cnt     <= wr_cnt + ADDR_W'(1);
            end
        end
    end

    // Even rows park their pair sums here; odd rows consume them
    always_ff @(posedge clk) begin
        if (t_valid && t_x[0] && !t_y[0])
            line_buf[lb_idx] <= pair_sum;
    end
endmodule

// File: doc/downscale_avg2x.md
# downscale_avg2x

Upstream image-preparation stage feeding the dual-port framebuffer. On a start request it streams a 160x120 8-bit source image out of the synchronous ROM and writes a half-resolution 80x60 image into the framebuffer write port. Each output pixel is the mean of the corresponding 2x2 source block, which replaces plain decimation. It shares the ROM and RAM port conventions of the existing copier, so either block can drive the framebuffer.

## Interface
- IMG_W, 160, source width in pixels; must be even
- IMG_H, 120, source height in pixels; must be even
- ADDR_W, 19, ROM/RAM address width
- PIX_W, 8, pixel width
- clk  in  1  pixel clock (25 MHz VGA clock domain)
- reset  in  1  synchronous, active-low; sampled on rising clk
- start  in  1  request a conversion; sampled only in IDLE or DONE
- rom_addr  out  ADDR_W  ROM read address
- rom_data  in  PIX_W  ROM data; valid one cycle after rom_addr
- ram_wraddr  out  ADDR_W  framebuffer write address
- ram_data  out  PIX_W  framebuffer write data
- ram_wren  out  1  framebuffer write strobe, one write per high cycle
- busy  out  1  high while a conversion is in progress
- done  out  1  high from completion until the next accepted start or reset

## Operation
- FSM states and transitions:
  - IDLE -> READ on start.
  - READ -> DRAIN after address IMG_W*IMG_H-1 has been issued.
  - DRAIN -> DONE after the last write.
  - DONE -> READ on start.
- READ issues one ROM address per cycle, 0 to IMG_W*IMG_H-1, raster order. There are no stalls.
- A registered x/y tag travels alongside each read, so x/y match the returning rom_data.
- Horizontal pair sum: on even x, hold the pixel. On odd x, form the 9-bit sum of the held and current pixels.
- Even row: store the 9-bit pair sum into line buffer entry x/2. The buffer has IMG_W/2 entries of 9 bits.
- Odd row: total = pair sum + line buffer[x/2], 10 bits wide. Register a write with:
  - ram_data = (total+2)>>2, or total>>2 when rounding is disabled (see Configuration). Taken as 8 bits, this never overflows.
  - ram_wraddr taken from a write counter, 0 to (IMG_W/2)*(IMG_H/2)-1, incremented after each write. No multiplier is used.
- Write count is exactly IMG_W*IMG_H/4 (4800 at the defaults).
- Line buffer contents are don't-care at start. Every entry is written on the even row before it is read.
- start in READ/DRAIN is ignored. start held high in DONE restarts immediately.
- Reset (reset=0 at a clk edge), including mid-conversion:
  - Next cycle: state=IDLE, rom_addr=0, ram_wraddr=0, ram_data=0, ram_wren=0, busy=0, done=0.
  - Pipeline tags and counters are cleared.
  - A write in flight is dropped.

## Timing
- The edge sampling start is cycle 0.
- Cycle 1: busy=1, rom_addr=0.
- Cycle k+1: rom_addr=k.
- ROM latency is 1 cycle. The pair/total stage is combinational from rom_data into the write registers.
- The write for block (i,j) is presented 2 cycles after the address of source pixel (2i+1, 2j+1).
- N = IMG_W*IMG_H. The last address is issued in cycle N, and the last ram_wren is high in cycle N+2.
- Cycle N+3: busy=0, done=1. At the defaults this is cycle 19203.
- ram_wren is never high outside busy. Outside writes, ram_data and ram_wraddr hold their last value.
- Throughput: one source pixel per clock.

## Configuration
- DOWNSCALE_ROUND_EN defined: ram_data = (total+2)>>2, round-half-up.
- DOWNSCALE_ROUND_EN undefined: ram_data = total>>2, truncation. The +2 adder is removed.
- Counts, addresses and timing are identical either way.

## Test plan
- Constant ROM 0x80, pulse start -> 4800 writes, all data 0x80, addresses 0..4799 ascending. done rises at cycle 19203, busy high for cycles 1..19202.
- Block (0,0) = 10, 20, 30, 40 (top-left, top-right, bottom-left, bottom-right); rest 0 -> ram[0]=25, ram[1..4799]=0.
- Block (0,0) = 1, 2, 2, 2 -> ram[0]=2 with DOWNSCALE_ROUND_EN, 1 without.
- All ROM 0xFF -> every write 0xFF, no wrap.
- Drive reset low at cycle 5000 -> next cycle wren=0, busy=0, done=0, rom_addr=0. A subsequent start produces a full correct frame.
- start pulsed at cycle 100 while busy -> ignored, done still at 19203. start held high through DONE -> busy again next cycle, rom_addr restarts at 0.
